// File: rtl/stdp_update_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package  : stdp_pkg
// Purpose  : Shared defaults, update-kind encoding and saturating arithmetic
//            for the STDP weight-update scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package stdp_pkg;

   localparam int N_SYN_DEF   = 8;
   localparam int W_WIDTH_DEF = 8;
   localparam int T_WIDTH_DEF = 4;
   localparam int WINDOW_DEF  = 8;
   localparam int A_PLUS_DEF  = 4;
   localparam int A_MINUS_DEF = 2;
   localparam int W_INIT_DEF  = 128;
   localparam int IDX_W_DEF   = $clog2(N_SYN_DEF);

   typedef enum logic {
      UPD_LTD = 1'b0,
      UPD_LTP = 1'b1
   } upd_kind_t;

   // Operands arrive zero-extended; the extra carry bit keeps the cap exact.
   function automatic logic [31:0] sat_add(input logic [31:0] w,
                                           input logic [31:0] inc,
                                           input logic [31:0] w_max);
      logic [32:0] s;
      s = {1'b0, w} + {1'b0, inc};
      return (s > {1'b0, w_max}) ? w_max : s[31:0];
   endfunction

   function automatic logic [31:0] sat_sub(input logic [31:0] w,
                                           input logic [31:0] dec);
      return (w >= dec) ? (w - dec) : 32'd0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stdp_update_scheduler_picker.sv
`default_nettype none
// ============================================================================
// Module   : stdp_rr_picker
// Purpose  : Rotating-priority picker: first requester at or after rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module stdp_rr_picker #(
   parameter int N_SYN = 8,
   parameter int IDX_W = 3
) (
   input  logic [N_SYN-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   int               w_pos;
   logic [IDX_W-1:0] w_sel;

   // Walk from farthest to nearest so the nearest requester is assigned last.
   always_comb begin
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      w_pos     = 0;
      w_sel     = '0;
      for (int k = N_SYN - 1; k >= 0; k--) begin
         w_pos = int'(rr_ptr) + k;
         if (w_pos >= N_SYN) w_pos = w_pos - N_SYN;
         w_sel = IDX_W'(w_pos);
         if (req[w_sel]) begin
            gnt_idx   = w_sel;
            gnt_valid = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/stdp_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : stdp_update_scheduler
// Purpose  : Spike-timing pairing into LTP/LTD requests, retired one per cycle
//            through a shared saturating weight adder.
// Revision : 1.0 - initial release
// ============================================================================
module stdp_update_scheduler
   import stdp_pkg::*;
#(
   parameter int          N_SYN   = N_SYN_DEF,
   parameter int          W_WIDTH = W_WIDTH_DEF,
   parameter int          T_WIDTH = T_WIDTH_DEF,
   parameter int unsigned WINDOW  = WINDOW_DEF,
   parameter int unsigned A_PLUS  = A_PLUS_DEF,
   parameter int unsigned A_MINUS = A_MINUS_DEF,
   parameter int unsigned W_INIT  = W_INIT_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_SYN-1:0]         pre_spike,
   input  logic                     post_spike,
   input  logic [$clog2(N_SYN)-1:0] rd_sel,
   output logic [W_WIDTH-1:0]       weight_out,
   output logic                     busy,
   output logic                     upd_valid,
   output logic [$clog2(N_SYN)-1:0] upd_idx,
   output logic                     upd_ltp
);

   localparam int                 IDX_W    = $clog2(N_SYN);
   localparam logic [T_WIDTH-1:0] c_T_MAX  = '1;
   localparam logic [W_WIDTH-1:0] c_W_MAX  = '1;
   localparam logic [W_WIDTH-1:0] c_W_INIT = W_WIDTH'(W_INIT);
   localparam logic [IDX_W-1:0]   c_LAST   = IDX_W'(N_SYN - 1);

   logic [N_SYN-1:0]   r_pre_q, r_pre_prev, r_ltp_pend, r_ltd_pend;
   logic               r_post_q, r_post_prev;
   logic [T_WIDTH-1:0] r_pre_t [N_SYN];
   logic [T_WIDTH-1:0] r_post_t;
   logic [W_WIDTH-1:0] r_weight [N_SYN];
   logic [IDX_W-1:0]   r_rr_ptr, r_upd_idx;
   logic               r_upd_valid;
   upd_kind_t          r_upd_kind;

   logic [N_SYN-1:0]   w_pre_ev, w_ltp_set, w_ltd_set, w_req, w_gnt_oh;
   logic [N_SYN-1:0]   w_clr_ltp, w_clr_ltd;
   logic               w_post_ev, w_gnt_valid, w_gnt_ltp;
   logic [IDX_W-1:0]   w_gnt_idx;
   logic [W_WIDTH-1:0] w_cur, w_new;

   assign w_pre_ev  = r_pre_q & ~r_pre_prev;
   assign w_post_ev = r_post_q & ~r_post_prev;

   // Pairing reads pre-update timers, so a coincident pre/post pair never matches itself.
   for (genvar i = 0; i < N_SYN; i++) begin : g_syn
      assign w_ltp_set[i] = w_post_ev   & (32'(r_pre_t[i]) < WINDOW);
      assign w_ltd_set[i] = w_pre_ev[i] & (32'(r_post_t) < WINDOW);
   end

   assign w_req = r_ltp_pend | r_ltd_pend;
   assign busy  = |w_req;

   stdp_rr_picker #(
      .N_SYN (N_SYN),
      .IDX_W (IDX_W)
   ) u_picker (
      .req       (w_req),
      .rr_ptr    (r_rr_ptr),
      .gnt_idx   (w_gnt_idx),
      .gnt_valid (w_gnt_valid)
   );

   assign w_gnt_ltp = w_gnt_valid & r_ltp_pend[w_gnt_idx];
   assign w_gnt_oh  = {{(N_SYN-1){1'b0}}, w_gnt_valid} << w_gnt_idx;
   assign w_clr_ltp = w_gnt_ltp ? w_gnt_oh : '0;
   assign w_clr_ltd = w_gnt_ltp ? '0 : w_gnt_oh;

   assign w_cur = r_weight[w_gnt_idx];
   assign w_new = w_gnt_ltp ? W_WIDTH'(sat_add(32'(w_cur), A_PLUS, 32'(c_W_MAX)))
                            : W_WIDTH'(sat_sub(32'(w_cur), A_MINUS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre_q     <= '0;
         r_pre_prev  <= '0;
         r_post_q    <= 1'b0;
         r_post_prev <= 1'b0;
         r_post_t    <= c_T_MAX;
         r_ltp_pend  <= '0;
         r_ltd_pend  <= '0;
         r_rr_ptr    <= '0;
         r_upd_valid <= 1'b0;
         r_upd_idx   <= '0;
         r_upd_kind  <= UPD_LTD;
         for (int i = 0; i < N_SYN; i++) begin
            r_pre_t[i]  <= c_T_MAX;
            r_weight[i] <= c_W_INIT;
         end
      end else begin
         r_pre_q     <= pre_spike;
         r_pre_prev  <= r_pre_q;
         r_post_q    <= post_spike;
         r_post_prev <= r_post_q;
         r_post_t    <= w_post_ev ? '0 :
                        (r_post_t == c_T_MAX) ? c_T_MAX : r_post_t + T_WIDTH'(1);
         for (int i = 0; i < N_SYN; i++) begin
            r_pre_t[i] <= w_pre_ev[i] ? '0 :
                          (r_pre_t[i] == c_T_MAX) ? c_T_MAX : r_pre_t[i] + T_WIDTH'(1);
         end
         // A new request on the bit being served wins over its clear.
         r_ltp_pend  <= (r_ltp_pend & ~w_clr_ltp) | w_ltp_set;
         r_ltd_pend  <= (r_ltd_pend & ~w_clr_ltd) | w_ltd_set;
         r_upd_valid <= w_gnt_valid;
         r_upd_idx   <= w_gnt_idx;
         r_upd_kind  <= w_gnt_ltp ? UPD_LTP : UPD_LTD;
         if (w_gnt_valid) begin
            r_weight[w_gnt_idx] <= w_new;
            r_rr_ptr            <= (w_gnt_idx == c_LAST) ? '0 : w_gnt_idx + IDX_W'(1);
         end
      end
   end

   assign weight_out = r_weight[rd_sel];
   assign upd_valid  = r_upd_valid;
   assign upd_idx    = r_upd_idx;
   assign upd_ltp    = (r_upd_kind == UPD_LTP);

endmodule
`default_nettype wire

// File: tb/tb_stdp_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_stdp_update_scheduler
// Purpose  : Directed scoreboard bench for the STDP update scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stdp_update_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] pre_spike;
   logic       post_spike;
   logic [2:0] rd_sel;
   logic [7:0] weight_out;
   logic       busy, upd_valid, upd_ltp;
   logic [2:0] upd_idx;

   typedef struct {
      logic [2:0] idx;
      logic       ltp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   stdp_update_scheduler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pre_spike  (pre_spike),
      .post_spike (post_spike),
      .rd_sel     (rd_sel),
      .weight_out (weight_out),
      .busy       (busy),
      .upd_valid  (upd_valid),
      .upd_idx    (upd_idx),
      .upd_ltp    (upd_ltp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every write pulse must match the oldest expected update.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && upd_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_upd: got idx %0d ltp %0d expected no update", upd_idx, upd_ltp);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("upd_idx", 32'(upd_idx), 32'(e.idx));
            check("upd_ltp", 32'(upd_ltp), 32'(e.ltp));
         end
      end
   end

   task automatic push(input int idx, input bit ltp);
      exp_t e;
      e.idx = 3'(idx);
      e.ltp = ltp;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic spike(input logic [7:0] pre, input logic post);
      @(posedge clk); #1;
      pre_spike  = pre;
      post_spike = post;
      @(posedge clk); #1;
      pre_spike  = '0;
      post_spike = 1'b0;
   endtask

   task automatic check_w(input int idx, input int exp);
      rd_sel = 3'(idx);
      #1;
      check($sformatf("weight[%0d]", idx), 32'(weight_out), 32'(exp));
   endtask

   task automatic drain(input int budget);
      int c;
      c = 0;
      while ((sb.size() != 0 || busy) && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("drain_in_budget", 32'(c < budget), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_busy, n_valid, c;

      rst_n      = 1'b0;
      pre_spike  = '0;
      post_spike = 1'b0;
      rd_sel     = '0;
      idle(3); #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_upd_valid", 32'(upd_valid), 32'd0);
      for (int i = 0; i < 8; i++) check_w(i, 128);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(20);

      // Pre on 3 then post inside the window: LTP on 3.
      push(3, 1'b1);
      spike(8'h08, 1'b0);
      idle(3);
      spike(8'h00, 1'b1);
      drain(50);
      idle(20);
      for (int i = 0; i < 8; i++) check_w(i, (i == 3) ? 132 : 128);

      // Post then pre on 2 inside the window: LTD on 2.
      push(2, 1'b0);
      spike(8'h00, 1'b1);
      idle(2);
      spike(8'h04, 1'b0);
      drain(50);
      idle(20);
      check_w(2, 126);
      check_w(3, 132);

      // Pre on 1, post ten cycles later: outside the window, nothing queued.
      n_busy = 0;
      spike(8'h02, 1'b0);
      idle(9);
      spike(8'h00, 1'b1);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (busy) n_busy++;
      end
      check("outside_window_busy_cycles", 32'(n_busy), 32'd0);
      check_w(1, 128);
      idle(10);

      // Mid-scan reset; scan resumes after idx 2 from the earlier LTD.
      for (int i = 3; i < 8; i++) push(i, 1'b1);
      for (int i = 0; i < 3; i++) push(i, 1'b1);
      spike(8'hFF, 1'b0);
      spike(8'h00, 1'b1);
      c = 0;
      while (sb.size() > 5 && c < 40) begin
         @(negedge clk);
         c++;
      end
      check("midscan_progress", 32'(c < 40), 32'd1);
      rst_n = 1'b0;
      sb.delete();
      idle(2); #1;
      check("midscan_reset_busy", 32'(busy), 32'd0);
      check("midscan_reset_upd_valid", 32'(upd_valid), 32'd0);
      for (int i = 0; i < 8; i++) check_w(i, 128);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(20);

      // All pre bits together, post two cycles later: eight back-to-back LTPs.
      for (int i = 0; i < 8; i++) push(i, 1'b1);
      n_busy  = 0;
      n_valid = 0;
      spike(8'hFF, 1'b0);
      idle(1);
      spike(8'h00, 1'b1);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (busy) n_busy++;
         if (upd_valid) n_valid++;
      end
      check("burst_busy_cycles", 32'(n_busy), 32'd8);
      check("burst_upd_cycles", 32'(n_valid), 32'd8);
      drain(50);
      for (int i = 0; i < 8; i++) check_w(i, 132);

      // Drive weight[0] into the upper cap with repeated LTP pairings.
      for (int n = 0; n < 32; n++) begin
         push(0, 1'b1);
         spike(8'h01, 1'b0);
         idle(1);
         spike(8'h00, 1'b1);
         idle(12);
      end
      drain(50);
      check_w(0, 255);
      check_w(1, 132);

      // Then drive it to the floor with repeated LTD pairings.
      for (int n = 0; n < 128; n++) begin
         push(0, 1'b0);
         spike(8'h00, 1'b1);
         idle(1);
         spike(8'h01, 1'b0);
         idle(12);
      end
      drain(50);
      check_w(0, 0);
      check_w(7, 132);

      idle(10);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
